// File: rtl/ping_pong_counter_gen.sv
// Bounded up/down counter (ping-pong, wrap-up, wrap-down, hold) with prescaled tick, programmable step and halt on bad bounds.
// Latency: out, step_pulse and bounce update on the tick edge; halted follows the state register.
// Backpressure: none; enable=0 freezes the prescaler and the count.
module ping_pong_counter_gen #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2,
    parameter int DIV    = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    input  logic              flip,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max,
    input  logic [WIDTH-1:0]  min,
    output logic [WIDTH-1:0]  out,
    output logic              direction,
    output logic              step_pulse,
    output logic              bounce,
    output logic              halted
);

    // A 1-bit prescaler is kept for DIV=1 so the register never has zero width.
    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam logic [1:0] MODE_PP   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             dir_nxt;
    logic             sp_nxt;
    logic             bn_nxt;

    // Arithmetic is done one bit wider than the count so bound compares cannot wrap.
    logic [WIDTH:0]   s_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   min_plus;
    logic             bounds_ok;
    logic             in_range;
    logic             tick;
    logic             init_dir;
    logic             pp_dir;

    // Shared datapath terms: effective step, bound sums and the prescaler tick.
    always_comb begin
        s_ext     = (step == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(step);
        up_sum    = {1'b0, out} + s_ext;
        min_plus  = {1'b0, min} + s_ext;
        bounds_ok = (min < max);
        in_range  = (out >= min) && (out <= max);
        tick      = enable && (state == S_RUN) && (presc == PRESC_LAST);
        init_dir  = (mode != MODE_DOWN);
    end

    // Next-state and next-count logic; restart overrides everything else.
    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        dir_nxt   = direction;
        presc_nxt = presc;
        sp_nxt    = 1'b0;
        bn_nxt    = 1'b0;
        pp_dir    = direction;

        if (restart) begin
            out_nxt   = min;
            dir_nxt   = init_dir;
            presc_nxt = '0;
            state_nxt = bounds_ok ? S_RUN : S_HALT;
        end else begin
            case (state)
                S_INIT: begin
                    out_nxt   = min;
                    dir_nxt   = init_dir;
                    state_nxt = bounds_ok ? S_RUN : S_HALT;
                end

                S_HALT: begin
                    if (bounds_ok) begin
                        state_nxt = S_RUN;
                        if (!in_range) begin
                            out_nxt = min;
                            dir_nxt = 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (enable) begin
                        presc_nxt = tick ? '0 : presc + PW'(1);
                    end
                    if (!bounds_ok || !in_range) begin
                        state_nxt = S_HALT;
                    end else begin
                        case (mode)
                            MODE_PP: begin
                                // Sitting on a bound pins the direction; elsewhere flip toggles it.
                                if (out == max) begin
                                    pp_dir = 1'b0;
                                end else if (out == min) begin
                                    pp_dir = 1'b1;
                                end else if (flip) begin
                                    pp_dir = ~direction;
                                end
                                dir_nxt = pp_dir;
                                if (tick) begin
                                    sp_nxt = 1'b1;
                                    if (pp_dir) begin
                                        if (up_sum >= {1'b0, max}) begin
                                            out_nxt = max;
                                            dir_nxt = 1'b0;
                                            bn_nxt  = 1'b1;
                                        end else begin
                                            out_nxt = up_sum[WIDTH-1:0];
                                        end
                                    end else begin
                                        if ({1'b0, out} <= min_plus) begin
                                            out_nxt = min;
                                            dir_nxt = 1'b1;
                                            bn_nxt  = 1'b1;
                                        end else begin
                                            out_nxt = out - s_ext[WIDTH-1:0];
                                        end
                                    end
                                end
                            end

                            MODE_UP: begin
                                dir_nxt = 1'b1;
                                if (tick) begin
                                    sp_nxt = 1'b1;
                                    if (up_sum > {1'b0, max}) begin
                                        out_nxt = min;
                                        bn_nxt  = 1'b1;
                                    end else begin
                                        out_nxt = up_sum[WIDTH-1:0];
                                    end
                                end
                            end

                            MODE_DOWN: begin
                                dir_nxt = 1'b0;
                                if (tick) begin
                                    sp_nxt = 1'b1;
                                    if ({1'b0, out} < min_plus) begin
                                        out_nxt = max;
                                        bn_nxt  = 1'b1;
                                    end else begin
                                        out_nxt = out - s_ext[WIDTH-1:0];
                                    end
                                end
                            end

                            MODE_HOLD: begin
                                out_nxt = out;
                            end

                            default: begin
                                out_nxt = out;
                            end
                        endcase
                    end
                end

                default: begin
                    state_nxt = S_INIT;
                end
            endcase
        end
    end

    // State, count, prescaler and one-cycle flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_INIT;
            out        <= '0;
            direction  <= 1'b1;
            presc      <= '0;
            step_pulse <= 1'b0;
            bounce     <= 1'b0;
        end else begin
            state      <= state_nxt;
            out        <= out_nxt;
            direction  <= dir_nxt;
            presc      <= presc_nxt;
            step_pulse <= sp_nxt;
            bounce     <= bn_nxt;
        end
    end

    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_ping_pong_counter_gen.sv
// Bench for ping_pong_counter_gen: a DIV=1 and a DIV=4 instance share stimulus.
// Each is compared every cycle against an integer reference model of the counting rules.
// Directed scenarios come first, then a long randomized run with async resets.
module tb_ping_pong_counter_gen;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 2;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              restart;
    logic              flip;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  max;
    logic [WIDTH-1:0]  min;

    logic [WIDTH-1:0]  out1, out4;
    logic              dir1, dir4;
    logic              sp1, sp4;
    logic              bn1, bn4;
    logic              hlt1, hlt4;

    int n_chk;
    int n_err;

    // Reference model, index 0 = DIV 1, index 1 = DIV 4. phase: 0 init, 1 run, 2 halt.
    int m_out[2];
    int m_dir[2];
    int m_pre[2];
    int m_ph[2];
    int m_sp[2];
    int m_bn[2];

    int t1_out[8];
    int t1_bn[8];
    int cnt;

    ping_pong_counter_gen #(.WIDTH(WIDTH), .STEP_W(STEP_W), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .flip(flip),
        .mode(mode), .step(step), .max(max), .min(min),
        .out(out1), .direction(dir1), .step_pulse(sp1), .bounce(bn1), .halted(hlt1)
    );

    ping_pong_counter_gen #(.WIDTH(WIDTH), .STEP_W(STEP_W), .DIV(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .flip(flip),
        .mode(mode), .step(step), .max(max), .min(min),
        .out(out4), .direction(dir4), .step_pulse(sp4), .bounce(bn4), .halted(hlt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0;
            m_dir[k] = 1;
            m_pre[k] = 0;
            m_ph[k]  = 0;
            m_sp[k]  = 0;
            m_bn[k]  = 0;
        end
    endtask

    // Applies the counting rules for one clock edge using the inputs present at that edge.
    task automatic model_step(input int k, input int d_div);
        int  s, lo, hi, o, d;
        bit  tk;
        s  = (step == 0) ? 1 : int'(step);
        lo = int'(min);
        hi = int'(max);
        o  = m_out[k];
        d  = m_dir[k];
        m_sp[k] = 0;
        m_bn[k] = 0;
        if (restart) begin
            m_out[k] = lo;
            m_dir[k] = (mode == 2'b10) ? 0 : 1;
            m_pre[k] = 0;
            m_ph[k]  = (lo < hi) ? 1 : 2;
            return;
        end
        if (m_ph[k] == 0) begin
            m_out[k] = lo;
            m_dir[k] = (mode == 2'b10) ? 0 : 1;
            m_ph[k]  = (lo < hi) ? 1 : 2;
            return;
        end
        if (m_ph[k] == 2) begin
            if (lo < hi) begin
                m_ph[k] = 1;
                if (o < lo || o > hi) begin
                    m_out[k] = lo;
                    m_dir[k] = 1;
                end
            end
            return;
        end
        tk = enable && (m_pre[k] == d_div - 1);
        if (enable) m_pre[k] = tk ? 0 : m_pre[k] + 1;
        if (lo >= hi || o > hi || o < lo) begin
            m_ph[k] = 2;
            return;
        end
        case (mode)
            2'b00: begin
                if (o == hi) d = 0;
                else if (o == lo) d = 1;
                else if (flip) d = 1 - d;
                if (tk) begin
                    m_sp[k] = 1;
                    if (d == 1) begin
                        if (o + s >= hi) begin o = hi; d = 0; m_bn[k] = 1; end
                        else o = o + s;
                    end else begin
                        if (o <= lo + s) begin o = lo; d = 1; m_bn[k] = 1; end
                        else o = o - s;
                    end
                end
            end
            2'b01: begin
                d = 1;
                if (tk) begin
                    m_sp[k] = 1;
                    if (o + s > hi) begin o = lo; m_bn[k] = 1; end
                    else o = o + s;
                end
            end
            2'b10: begin
                d = 0;
                if (tk) begin
                    m_sp[k] = 1;
                    if (o < lo + s) begin o = hi; m_bn[k] = 1; end
                    else o = o - s;
                end
            end
            default: begin
            end
        endcase
        m_out[k] = o;
        m_dir[k] = d;
    endtask

    task automatic compare_all();
        chk("out_div1",    out1, m_out[0]);
        chk("dir_div1",    dir1, m_dir[0]);
        chk("pulse_div1",  sp1,  m_sp[0]);
        chk("bounce_div1", bn1,  m_bn[0]);
        chk("halt_div1",   hlt1, (m_ph[0] == 2) ? 1 : 0);
        chk("out_div4",    out4, m_out[1]);
        chk("dir_div4",    dir4, m_dir[1]);
        chk("pulse_div4",  sp4,  m_sp[1]);
        chk("bounce_div4", bn4,  m_bn[1]);
        chk("halt_div4",   hlt4, (m_ph[1] == 2) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, 1);
        model_step(1, 4);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out1"}, out1, 0);
        chk({tag, "_dir1"}, dir1, 1);
        chk({tag, "_sp1"},  sp1,  0);
        chk({tag, "_bn1"},  bn1,  0);
        chk({tag, "_hlt1"}, hlt1, 0);
        chk({tag, "_out4"}, out4, 0);
        chk({tag, "_hlt4"}, hlt4, 0);
    endtask

    // Asserts reset between clock edges and checks the outputs before any edge arrives.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        t1_out  = '{2, 3, 4, 5, 4, 3, 2, 3};
        t1_bn   = '{0, 0, 0, 1, 0, 0, 1, 0};
        reset   = 1'b1;
        enable  = 1'b1;
        restart = 1'b0;
        flip    = 1'b0;
        mode    = 2'b00;
        step    = 2'd1;
        min     = 4'd2;
        max     = 4'd5;
        model_reset();
        #12;
        check_reset_values("reset");
        reset = 1'b0;

        // Basic ping-pong between 2 and 5.
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t1_out", out1, t1_out[i]);
            chk("t1_bounce", bn1, t1_bn[i]);
        end

        // Step of 2 from 0 to 5, then step 0 acting as 1.
        min = 4'd0; step = 2'd2; restart = 1'b1;
        cycle();
        restart = 1'b0;
        repeat (16) cycle();
        step = 2'd0;
        repeat (12) cycle();

        // Flip pulses mid-range and on bounds.
        step = 2'd1;
        for (int i = 0; i < 30; i++) begin
            flip = (i % 3 == 1);
            cycle();
        end
        flip = 1'b0;

        // Wrap-up then wrap-down.
        mode = 2'b01; min = 4'd1; max = 4'd4; step = 2'd2; restart = 1'b1;
        cycle();
        restart = 1'b0;
        repeat (16) cycle();
        mode = 2'b10; step = 2'd1;
        repeat (20) cycle();

        // Halt on degenerate bounds, recovery, and out-of-range recovery.
        mode = 2'b00; min = 4'd3; max = 4'd3;
        cycle();
        chk("t5_halted", hlt1, 1);
        repeat (3) cycle();
        max = 4'd9;
        cycle();
        chk("t5_resume", hlt1, 0);
        repeat (20) cycle();
        max = 4'd6;
        repeat (4) cycle();

        // Prescaler: freeze, cadence after restart, hold mode.
        min = 4'd0; max = 4'd15; step = 2'd1; mode = 2'b00;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        cnt = 0;
        repeat (20) begin
            cycle();
            cnt += int'(sp4);
        end
        chk("t6_ticks", cnt, 5);
        enable = 1'b0;
        repeat (10) cycle();
        enable = 1'b1;
        repeat (6) cycle();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        repeat (9) cycle();
        mode = 2'b11;
        repeat (9) cycle();
        async_reset();

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 39) == 0);
            flip    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) step = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                min = 4'($urandom_range(0, 12));
                if ($urandom_range(0, 4) == 0) max = 4'($urandom_range(0, 15));
                else max = 4'(int'(min) + $urandom_range(1, 15 - int'(min)));
            end
            if (i == 1500) async_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ping_pong_counter_gen.md
Name: ping_pong_counter_gen

Overview:
Parametrised successor of the team's ping-pong counter. Width is generic and an internal prescaler replaces the external slow enable. It adds a programmable step size, four count modes (ping-pong, wrap-up, wrap-down, hold), a synchronous restart, and an explicit halt state for invalid or out-of-range bounds. It sits between the debounced/one-pulsed button logic and the 7-seg display driver in the FPGA top.

Parameters:
WIDTH, 4, bit width of out/max/min.
STEP_W, 2, bit width of step input.
DIV, 50_000_000, clk cycles per count tick; DIV=1 means a tick every cycle; must be >=1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; gates prescaler and counting
restart  in  1  one-cycle pulse; synchronous reload
flip  in  1  one-cycle pulse; reverse direction (ping-pong mode only)
mode  in  2  00 ping-pong, 01 wrap-up, 10 wrap-down, 11 hold
step  in  STEP_W  count increment; 0 treated as 1
max  in  WIDTH  upper bound, inclusive
min  in  WIDTH  lower bound, inclusive
out  out  WIDTH  current count
direction  out  1  1 = up, 0 = down
step_pulse  out  1  high for one cycle after each edge that updated out by a tick
bounce  out  1  high for one cycle after each edge where a bound forced a reversal or wrap
halted  out  1  high while in HALT

Behaviour:
- Reset (async, immediate, no clock needed):
  - out=0, direction=1, step_pulse=0, bounce=0, halted=0.
  - Prescaler=0, state=INIT.
- States INIT, RUN, HALT:
  - INIT: next edge loads out<=min and direction<=(mode==10 ? 0 : 1). Goes to RUN if min<max, else HALT.
  - RUN: leave to HALT on the edge where min>=max, or out>max, or out<min.
  - HALT: halted=1, out and direction held. When min<max again: if out is in [min,max], return to RUN; otherwise out<=min, direction<=1, then RUN. halted falls at the same edge.
- Prescaler:
  - Counts 0..DIV-1, only while enable=1 and state=RUN; otherwise holds its value.
  - tick = (prescaler==DIV-1) && enable && RUN. Prescaler returns to 0 on tick.
- restart (any state): out<=min, direction<=1 (0 in wrap-down), prescaler<=0, state<=INIT's target. Has priority over tick and flip in the same cycle.
- Effective step s = (step==0) ? 1 : step. Sums and differences are computed in WIDTH+1 bits; the count never overflows or underflows.
- Ping-pong (00):
  - Flip handling: out==max forces direction 0; out==min forces direction 1; otherwise a flip toggles direction at that edge.
  - If tick and flip coincide, the step uses the post-flip direction.
  - Up tick: if out+s>=max then out<=max, direction<=0, bounce. Else out<=out+s.
  - Down tick: if out<=min+s then out<=min, direction<=1, bounce. Else out<=out-s.
- Wrap-up (01): direction=1. Tick: if out+s>max then out<=min, bounce. Else out<=out+s. flip ignored.
- Wrap-down (10): direction=0. Tick: if out<min+s then out<=max, bounce. Else out<=out-s. flip ignored.
- Hold (11): out held, no step_pulse; prescaler still runs.
- Mode change mid-run: takes effect on the next edge; direction is forced per mode rules.
- Output latency: out changes on the tick edge. step_pulse and bounce are registered on that same edge, so they are high during the following cycle.

Test Plan:
1. WIDTH=4, DIV=1, mode=00, min=2, max=5, step=1, enable=1, release reset -> out after INIT: 2,3,4,5,4,3,2,3; bounce high after reaching 5 and after reaching 2.
2. min=0, max=5, step=2, mode=00 -> out 0,2,4,5,3,1,0,2; bounce at 5 and 0. Then step=0 -> steps of 1.
3. mode=00, flip pulse while out=3 counting up -> next out 2, direction=0. Flip pulse while out==max -> ignored, direction stays 0.
4. mode=01, min=1, max=4, step=2 -> 1,3,1,3 with bounce on each wrap. mode=10, step=1 -> 1,4,3,2,1,4, direction=0.
5. min=max=3 -> halted=1 next edge, out held. Set max=9 -> halted=0, counting resumes from the held out. Set max=6 while out=8 -> HALT, then out<=min and RUN.
6. DIV=4: with enable low, prescaler and out freeze; with enable high, exactly one step per 4 clocks. restart mid-count -> out=min and a full 4-cycle wait before the next step. reset asserted between edges -> out=0, halted=0 immediately without a clock edge.
